// File: rtl/sram_handshake_bridge.sv
// Purpose  : bridges an SRAM-style CPU data port onto an addr_ok/data_ok split-handshake memory bus.
// Latency  : request issued the cycle after cpu_en; cpu_rdata valid the cycle after data_ok (min 2 cycles).
// Backpress: cpu_stall freezes the CPU while a request is pending; mem_req holds until addr_ok.
//
// Ports:
//   clk, resetn                      clock and async active-low reset
//   cpu_en/we/addr/wdata -> rdata    SRAM-style CPU side; cpu_stall holds the requesting stage
//   mem_req/wr/wstrb/size/addr/wdata request channel, accepted by mem_addr_ok
//   mem_data_ok/mem_rdata            completion channel
module sram_handshake_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wr_q,    wr_d;
  logic        stall_c;
  logic        req_c;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wstrb_d = wstrb_q;
    wr_d    = wr_q;
    stall_c = 1'b0;
    req_c   = 1'b0;

    case (state_q)
      IDLE: begin
        stall_c = cpu_en;
        if (cpu_en) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_we;
          wr_d    = |cpu_we;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        // data_ok only counts once the address phase has been accepted
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            state_d = DONE;
            if (!wr_q) rdata_d = mem_rdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (mem_data_ok) begin
          state_d = DONE;
          if (!wr_q) rdata_d = mem_rdata;
        end
      end
      DONE: begin
        // cpu_en here is still the request just served, so it is not restarted
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wstrb_q <= wstrb_d;
      wr_q    <= wr_d;
    end
  end

  assign cpu_stall = stall_c;
  assign cpu_rdata = rdata_q;
  assign mem_req   = req_c;
  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_size  = 2'd2;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sram_handshake_bridge.sv
// Directed, table-driven bench for sram_handshake_bridge.
module tb_sram_handshake_bridge;

  logic        clk;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  sram_handshake_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_wstrb  (mem_wstrb),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        x_stall;
    logic        x_req;
    logic        x_wr;
    logic [3:0]  x_wstrb;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic rstn, input logic en, input logic [3:0] we,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic aok, input logic dok, input logic [31:0] rdata,
    input logic x_stall, input logic x_req, input logic x_wr,
    input logic [3:0] x_wstrb, input logic [31:0] x_addr,
    input logic [31:0] x_wdata, input logic [31:0] x_rdata);
    vec_t v;
    v.rstn = rstn; v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.x_stall = x_stall; v.x_req = x_req; v.x_wr = x_wr; v.x_wstrb = x_wstrb;
    v.x_addr = x_addr; v.x_wdata = x_wdata; v.x_rdata = x_rdata;
    return v;
  endfunction

  task automatic drive(input logic rstn, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic aok, input logic dok, input logic [31:0] rdata);
    resetn = rstn; cpu_en = en; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h1C00_0010;
  localparam logic [31:0] A1 = 32'h1C00_0020;
  localparam logic [31:0] A2 = 32'h1C00_0030;
  localparam logic [31:0] A3 = 32'h1C00_0040;
  localparam logic [31:0] AX = 32'hFFFF_0000;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] WD = 32'h1234_5678;
  localparam logic [31:0] CF = 32'hCAFE_F00D;

  initial begin
    logic [73:0] got_v, exp_v;

    //             rst en we    addr wdata aok dok rdata            stl req wr wstrb addr wdata rdata
    tbl[0]  = mk(0, 0, 4'h0, 0,  0,  0, 0, 32'h0,          0, 0, 0, 4'h0, 0,  0,  0);   // reset state
    tbl[1]  = mk(0, 1, 4'h0, A0, 0,  0, 0, 32'h0,          1, 0, 0, 4'h0, 0,  0,  0);   // stall follows en in reset
    tbl[2]  = mk(1, 1, 4'h0, A0, 0,  0, 0, 32'h0,          1, 0, 0, 4'h0, 0,  0,  0);   // read issue (IDLE)
    tbl[3]  = mk(1, 1, 4'h0, A0, 0,  1, 1, DB,             1, 1, 0, 4'h0, A0, 0,  0);   // REQ, zero wait
    tbl[4]  = mk(1, 1, 4'h0, A0, 0,  0, 0, 32'h0,          0, 0, 0, 4'h0, A0, 0,  DB);  // DONE
    tbl[5]  = mk(1, 0, 4'h0, A0, 0,  0, 0, 32'h0,          0, 0, 0, 4'h0, A0, 0,  DB);  // IDLE
    tbl[6]  = mk(1, 1, 4'h3, A1, WD, 0, 0, 32'h0,          1, 0, 0, 4'h0, A0, 0,  DB);  // write issue
    tbl[7]  = mk(1, 1, 4'hF, AX, 0,  0, 0, 32'h0,          1, 1, 1, 4'h3, A1, WD, DB);  // REQ held, cpu inputs wander
    tbl[8]  = mk(1, 1, 4'hF, AX, 0,  0, 0, 32'h0,          1, 1, 1, 4'h3, A1, WD, DB);
    tbl[9]  = mk(1, 1, 4'hF, AX, 0,  0, 0, 32'h0,          1, 1, 1, 4'h3, A1, WD, DB);
    tbl[10] = mk(1, 1, 4'hF, AX, 0,  1, 0, 32'h0,          1, 1, 1, 4'h3, A1, WD, DB);  // addr_ok
    tbl[11] = mk(1, 1, 4'h3, A1, WD, 1, 0, 32'h5555_5555,  1, 0, 1, 4'h3, A1, WD, DB);  // WAIT, addr_ok ignored
    tbl[12] = mk(1, 1, 4'h3, A1, WD, 0, 1, 32'h5555_5555,  1, 0, 1, 4'h3, A1, WD, DB);  // data_ok on write
    tbl[13] = mk(1, 1, 4'h3, A1, WD, 0, 0, 32'h0,          0, 0, 1, 4'h3, A1, WD, DB);  // DONE, rdata unchanged
    tbl[14] = mk(1, 1, 4'h0, A2, 0,  0, 0, 32'h0,          1, 0, 1, 4'h3, A1, WD, DB);  // back-to-back from IDLE
    tbl[15] = mk(1, 1, 4'h0, A2, 0,  1, 0, 32'h0,          1, 1, 0, 4'h0, A2, 0,  DB);
    tbl[16] = mk(1, 1, 4'h0, A2, 0,  0, 1, CF,             1, 0, 0, 4'h0, A2, 0,  DB);  // WAIT data_ok
    tbl[17] = mk(1, 1, 4'h0, A2, 0,  1, 1, 32'h1111_1111,  0, 0, 0, 4'h0, A2, 0,  CF);  // DONE: en/aok/dok ignored
    tbl[18] = mk(1, 0, 4'h0, A2, 0,  1, 1, 32'hFFFF_FFFF,  0, 0, 0, 4'h0, A2, 0,  CF);  // spurious in IDLE
    tbl[19] = mk(1, 0, 4'h0, A2, 0,  0, 0, 32'h0,          0, 0, 0, 4'h0, A2, 0,  CF);
    tbl[20] = mk(1, 1, 4'h0, A3, 0,  0, 0, 32'h0,          1, 0, 0, 4'h0, A2, 0,  CF);
    tbl[21] = mk(1, 1, 4'h0, A3, 0,  1, 0, 32'h0,          1, 1, 0, 4'h0, A3, 0,  CF);
    tbl[22] = mk(1, 1, 4'h0, A3, 0,  0, 0, 32'h0,          1, 0, 0, 4'h0, A3, 0,  CF);  // WAIT
    tbl[23] = mk(0, 0, 4'h0, A3, 0,  0, 0, 32'h0,          0, 0, 0, 4'h0, 0,  0,  0);   // reset in WAIT
    tbl[24] = mk(1, 0, 4'h0, A3, 0,  0, 1, 32'h9999_9999,  0, 0, 0, 4'h0, 0,  0,  0);   // late data_ok
    tbl[25] = mk(1, 0, 4'h0, A3, 0,  0, 0, 32'h0,          0, 0, 0, 4'h0, 0,  0,  0);

    drive(0, 0, 4'h0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      if (i > 0) step();
      drive(tbl[i].rstn, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].aok, tbl[i].dok, tbl[i].rdata);
      @(negedge clk);
      got_v = {cpu_stall, mem_req, mem_wr, mem_wstrb, mem_addr, mem_size, cpu_rdata};
      exp_v = {tbl[i].x_stall, tbl[i].x_req, tbl[i].x_wr, tbl[i].x_wstrb,
               tbl[i].x_addr, 2'd2, tbl[i].x_rdata};
      n_vec++;
      if (got_v !== exp_v || mem_wdata !== tbl[i].x_wdata) begin
        n_bad++;
        $display("FAIL vec%0d: got stall/req/wr/strb/addr/size/rdata=%h wdata=%h, expected %h wdata=%h",
                 i, got_v, mem_wdata, exp_v, tbl[i].x_wdata);
      end
    end

    // Long addr_ok backpressure: request must hold with no timeout.
    step();
    drive(1, 1, 4'h0, 32'h1C00_0050, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_issue_stall", {31'd0, cpu_stall}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      drive(1, 1, 4'h0, 32'h0BAD_0000 + k, 0, 0, 0, 0);
      @(negedge clk);
      chk("seq_hold_req", {31'd0, mem_req}, 32'd1);
      chk("seq_hold_addr", mem_addr, 32'h1C00_0050);
    end
    step();
    drive(1, 1, 4'h0, 32'h1C00_0050, 0, 1, 1, 32'h0BAD_F00D);
    @(negedge clk);
    chk("seq_accept_req", {31'd0, mem_req}, 32'd1);
    // DONE with cpu_en still high: no stall, no request, data visible.
    step();
    drive(1, 1, 4'h0, 32'h1C00_0060, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_done_stall", {31'd0, cpu_stall}, 32'd0);
    chk("seq_done_req", {31'd0, mem_req}, 32'd0);
    chk("seq_done_rdata", cpu_rdata, 32'h0BAD_F00D);
    // Following IDLE, then the new request two cycles after data_ok.
    step();
    @(negedge clk);
    chk("seq_idle_req", {31'd0, mem_req}, 32'd0);
    chk("seq_idle_stall", {31'd0, cpu_stall}, 32'd1);
    step();
    drive(1, 1, 4'h0, 32'h1C00_0060, 0, 1, 1, 32'h7777_7777);
    @(negedge clk);
    chk("seq_next_req", {31'd0, mem_req}, 32'd1);
    chk("seq_next_addr", mem_addr, 32'h1C00_0060);
    step();
    drive(1, 0, 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_next_rdata", cpu_rdata, 32'h7777_7777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_handshake_bridge.md
SRAM_HANDSHAKE_BRIDGE -- requirements
Module: sram_handshake_bridge

Interface
REQ-001 Parameters: none; the data path is fixed at 32-bit words.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports are named clk and resetn.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 cpu_en  input  1  CPU data-memory access request, SRAM-style.
REQ-006 cpu_we  input  4  byte write enables; 0 = read.
REQ-007 cpu_addr  input  32  byte address.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data, registered.
REQ-010 cpu_stall  output  1  freezes the CPU stage that is presenting the request.
REQ-011 mem_req  output  1  memory request valid.
REQ-012 mem_wr  output  1  1 = write.
REQ-013 mem_wstrb  output  4  byte strobes.
REQ-014 mem_size  output  2  fixed value 2'd2 (word).
REQ-015 mem_addr  output  32  request address.
REQ-016 mem_wdata  output  32  write data.
REQ-017 mem_addr_ok  input  1  memory accepted the request.
REQ-018 mem_data_ok  input  1  memory completed the request; rdata is valid on reads.
REQ-019 mem_rdata  input  32  read data.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, with one request outstanding at most.
REQ-021 IDLE & cpu_en: latch cpu_addr, cpu_we, cpu_wdata and mem_wr=|cpu_we; next state REQ.
REQ-022 IDLE & !cpu_en: remain in IDLE.
REQ-023 cpu_stall SHALL be combinational: 1 in REQ and WAIT, 1 in IDLE when cpu_en=1, and 0 otherwise (including in DONE).
REQ-024 mem_req SHALL be 1 exactly in REQ, and mem_addr, mem_wr, mem_wstrb and mem_wdata SHALL come from the latched registers and stay stable while mem_req=1.
REQ-025 REQ & mem_addr_ok & !mem_data_ok: go to WAIT.
REQ-026 REQ & mem_addr_ok & mem_data_ok: go to DONE.
REQ-027 REQ & !mem_addr_ok: hold REQ indefinitely, with no timeout.
REQ-028 WAIT & mem_data_ok: go to DONE.
REQ-029 WAIT & !mem_data_ok: hold WAIT.
REQ-030 On a read, cpu_rdata SHALL load mem_rdata on the clock edge at which data_ok is accepted.
REQ-031 cpu_rdata SHALL hold its value until the next accepted read, and writes SHALL never change it.
REQ-032 In DONE, cpu_en SHALL be ignored because it is the already-served request, and the next state SHALL be IDLE unconditionally.
REQ-033 A new access therefore starts at the earliest 2 cycles after the completing data_ok.
REQ-034 mem_addr_ok in IDLE, WAIT or DONE SHALL be ignored.
REQ-035 mem_data_ok in IDLE or DONE SHALL be ignored, and SHALL NOT load cpu_rdata.
REQ-036 Minimum read latency: cpu_en in cycle 0 with addr_ok and data_ok in cycle 1 gives DONE in cycle 2 (stall=0) and valid cpu_rdata from cycle 2.
REQ-037 Addresses SHALL pass through unmodified, with no alignment check.

Reset
REQ-038 resetn=0 SHALL asynchronously force state=IDLE, latched registers=0 and cpu_rdata=0.
REQ-039 During reset the outputs SHALL be mem_req=0, cpu_stall=cpu_en (combinational) and mem_size=2.
REQ-040 Reset in REQ or WAIT SHALL abandon the transaction, and a late data_ok afterwards SHALL be ignored as in REQ-035.
REQ-041 Deassertion of resetn SHALL be taken synchronously to clk by the surrounding reset logic.

Verification
REQ-042 Read, zero wait: cpu_en=1, we=0, addr=0x1C000010; memory gives addr_ok and data_ok in the same cycle with rdata=0xDEADBEEF -> one cycle with mem_req=1, stall high 2 cycles, cpu_rdata=0xDEADBEEF from DONE onward.
REQ-043 Write with backpressure: we=4'b0011, wdata=0x12345678; addr_ok delayed 3 cycles, data_ok 2 cycles later -> mem_req held 4 cycles with mem_wr=1, wstrb=0011, stable addr/data; cpu_rdata unchanged; stall drops in DONE.
REQ-044 Back-to-back: cpu_en held through DONE -> no second mem_req in DONE; new request issued from the following IDLE.
REQ-045 Spurious: data_ok=1 with rdata=0xFFFFFFFF while IDLE -> cpu_rdata unchanged, state stays IDLE.
REQ-046 Reset in WAIT: resetn pulsed low, then data_ok -> state IDLE, cpu_rdata=0, mem_req=0, late data_ok ignored.
